// File: rtl/pingpang_wr_ctrl.sv
// Write-side controller for the ping-pong buffer: streams words into the current
// bank and pulses switch once the bank is closed and the reader has let go of the other.
module pingpang_wr_ctrl #(
  parameter  int DATA_W = 16,
  parameter  int DEPTH  = 4,
  localparam int AW     = $clog2(DEPTH),
  localparam int LW     = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              wr_en,
  output logic [AW-1:0]     wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              wr_bank,
  output logic              switch,
  output logic              rd_bank,
  output logic              rd_bank_valid,
  output logic [LW-1:0]     rd_len,
  input  logic              rd_done
);

  typedef enum logic [1:0] {
    FILL = 2'd0,
    SWAP = 2'd1,
    WAIT = 2'd2
  } state_t;

  localparam logic [LW-1:0] FULL = LW'(DEPTH);

  state_t        state;
  logic [LW-1:0] cnt;
  logic [LW-1:0] cnt_inc;
  logic [LW-1:0] len_q;
  logic          rd_pend;
  logic          xfer;
  logic          close;

  assign in_ready      = (state == FILL) && !rst;
  assign xfer          = in_valid && (state == FILL);
  assign cnt_inc       = cnt + 1'b1;
  assign rd_bank       = ~wr_bank;
  assign rd_bank_valid = rd_pend;

  // A transfer takes precedence over flush; flush alone only closes a non-empty bank.
  assign close = (state == FILL) && (xfer ? (cnt_inc == FULL) : (flush && (cnt != '0)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= FILL;
      cnt     <= '0;
      len_q   <= '0;
      rd_pend <= 1'b0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      wr_bank <= 1'b0;
      switch  <= 1'b0;
      rd_len  <= '0;
    end else begin
      switch <= 1'b0;
      wr_en  <= xfer;
      if (xfer) begin
        wr_data <= in_data;
        wr_addr <= cnt[AW-1:0];
        cnt     <= cnt_inc;
      end
      case (state)
        FILL: begin
          if (rd_done) rd_pend <= 1'b0;
          if (close) begin
            len_q <= xfer ? cnt_inc : cnt;
            state <= (!rd_pend || rd_done) ? SWAP : WAIT;
          end
        end
        WAIT: begin
          if (rd_done) begin
            rd_pend <= 1'b0;
            state   <= SWAP;
          end
        end
        SWAP: begin
          // Handing the bank over re-arms rd_pend regardless of rd_done this cycle.
          switch  <= 1'b1;
          wr_bank <= ~wr_bank;
          rd_len  <= len_q;
          rd_pend <= 1'b1;
          cnt     <= '0;
          state   <= FILL;
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_pingpang_wr_ctrl.sv
// Bench for pingpang_wr_ctrl: directed scenario tasks followed by a randomized run
// checked against a bank-level behavioural model.
module tb_pingpang_wr_ctrl;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 4;
  localparam int AW     = $clog2(DEPTH);
  localparam int LW     = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_data = '0;
  logic              flush = 1'b0;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_bank;
  logic              switch;
  logic              rd_bank;
  logic              rd_bank_valid;
  logic [LW-1:0]     rd_len;
  logic              rd_done = 1'b0;

  int total = 0;
  int bad   = 0;

  // {in_ready, wr_en, switch, wr_bank, rd_bank, rd_bank_valid, rd_len}
  logic [5+LW:0] status;
  assign status = {in_ready, wr_en, switch, wr_bank, rd_bank, rd_bank_valid, rd_len};

  pingpang_wr_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .flush(flush), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_bank(wr_bank),
    .switch(switch), .rd_bank(rd_bank), .rd_bank_valid(rd_bank_valid), .rd_len(rd_len),
    .rd_done(rd_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [5+LW:0] exp_st;
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; rd_done = 1'b0;
    tick(); tick();
    exp_st = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0};
    total++;
    if (status !== exp_st) begin bad++; $display("FAIL reset_status got=%b want=%b", status, exp_st); end
    total++;
    if ({wr_addr, wr_data} !== '0) begin bad++; $display("FAIL reset_wr got addr=%0d data=%0d want 0/0", wr_addr, wr_data); end
    rst = 1'b0;
    tick();
    exp_st = {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0};
    total++;
    if (status !== exp_st) begin bad++; $display("FAIL reset_release got=%b want=%b", status, exp_st); end
    $display("test_reset done");
  endtask

  task automatic test_fast_swap();
    logic [5+LW:0] exp_st;
    in_valid = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      in_data = DATA_W'(i * 10);
      tick();
      total++;
      if ({in_ready, wr_en, switch, wr_bank, wr_addr, wr_data} !== {(i < DEPTH - 1), 1'b1, 1'b0, 1'b0, AW'(i), DATA_W'(i * 10)}) begin
        bad++;
        $display("FAIL fast_write[%0d] got rdy=%b en=%b sw=%b bank=%b addr=%0d data=%0d want addr=%0d data=%0d",
                 i, in_ready, wr_en, switch, wr_bank, wr_addr, wr_data, i, i * 10);
      end
    end
    in_valid = 1'b0;
    tick();
    exp_st = {1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 3'd4};
    total++;
    if (status !== exp_st) begin bad++; $display("FAIL fast_switch got=%b want=%b", status, exp_st); end
    tick();
    exp_st = {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 3'd4};
    total++;
    if (status !== exp_st) begin bad++; $display("FAIL fast_pulse_end got=%b want=%b", status, exp_st); end
    $display("test_fast_swap done");
  endtask

  task automatic test_back_pressure();
    logic [5+LW:0] exp_st;
    in_valid = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      in_data = DATA_W'(100 + i);
      tick();
      total++;
      if ({in_ready, wr_en, switch, wr_bank, wr_addr, wr_data} !== {(i < DEPTH - 1), 1'b1, 1'b0, 1'b1, AW'(i), DATA_W'(100 + i)}) begin
        bad++;
        $display("FAIL bp_write[%0d] got rdy=%b en=%b sw=%b bank=%b addr=%0d data=%0d", i, in_ready, wr_en, switch, wr_bank, wr_addr, wr_data);
      end
    end
    in_data = 16'hdead;
    for (int k = 0; k < 3; k++) begin
      tick();
      total++;
      if ({in_ready, wr_en, switch, wr_bank, rd_bank_valid} !== 5'b00011) begin
        bad++;
        $display("FAIL bp_wait[%0d] got rdy=%b en=%b sw=%b bank=%b rbv=%b want 0 0 0 1 1", k, in_ready, wr_en, switch, wr_bank, rd_bank_valid);
      end
    end
    in_valid = 1'b0;
    rd_done = 1'b1;
    tick();
    rd_done = 1'b0;
    exp_st = {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd4};
    total++;
    if (status !== exp_st) begin bad++; $display("FAIL bp_release got=%b want=%b", status, exp_st); end
    tick();
    exp_st = {1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3'd4};
    total++;
    if (status !== exp_st) begin bad++; $display("FAIL bp_switch got=%b want=%b", status, exp_st); end
    total++;
    if (wr_data !== DATA_W'(103)) begin bad++; $display("FAIL bp_no_extra got data=%0d want 103", wr_data); end
    $display("test_back_pressure done");
  endtask

  task automatic test_flush();
    logic [5+LW:0] exp_st;
    rd_done = 1'b1;
    tick();
    rd_done = 1'b0;
    exp_st = {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd4};
    total++;
    if (status !== exp_st) begin bad++; $display("FAIL flush_release got=%b want=%b", status, exp_st); end
    in_valid = 1'b1; in_data = 16'd200;
    tick();
    in_data = 16'd201;
    tick();
    total++;
    if ({wr_en, wr_addr, wr_data} !== {1'b1, AW'(1), DATA_W'(201)}) begin
      bad++; $display("FAIL flush_write got en=%b addr=%0d data=%0d want 1 1 201", wr_en, wr_addr, wr_data);
    end
    in_valid = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    total++;
    if ({in_ready, switch, wr_en} !== 3'b000) begin
      bad++; $display("FAIL flush_swap_cycle got rdy=%b sw=%b en=%b want 0 0 0", in_ready, switch, wr_en);
    end
    tick();
    exp_st = {1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 3'd2};
    total++;
    if (status !== exp_st) begin bad++; $display("FAIL flush_switch got=%b want=%b", status, exp_st); end
    $display("test_flush done");
  endtask

  task automatic test_same_cycle_release();
    logic [5+LW:0] exp_st;
    in_valid = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      in_data = DATA_W'(300 + i);
      rd_done = (i == DEPTH - 1);
      tick();
      total++;
      if ({wr_en, wr_addr, wr_data} !== {1'b1, AW'(i), DATA_W'(300 + i)}) begin
        bad++; $display("FAIL same_write[%0d] got en=%b addr=%0d data=%0d", i, wr_en, wr_addr, wr_data);
      end
    end
    rd_done = 1'b0; in_valid = 1'b0;
    exp_st = {1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd2};
    total++;
    if (status !== exp_st) begin bad++; $display("FAIL same_swap_cycle got=%b want=%b", status, exp_st); end
    tick();
    exp_st = {1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3'd4};
    total++;
    if (status !== exp_st) begin bad++; $display("FAIL same_switch got=%b want=%b", status, exp_st); end
    $display("test_same_cycle_release done");
  endtask

  task automatic test_ignored();
    logic [5+LW:0] exp_st;
    flush = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      exp_st = {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd4};
      total++;
      if (status !== exp_st) begin bad++; $display("FAIL ign_flush[%0d] got=%b want=%b", k, status, exp_st); end
    end
    flush = 1'b0;
    for (int k = 0; k < 2; k++) begin
      rd_done = 1'b1;
      tick();
      rd_done = 1'b0;
      exp_st = {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd4};
      total++;
      if (status !== exp_st) begin bad++; $display("FAIL ign_rd_done[%0d] got=%b want=%b", k, status, exp_st); end
    end
    in_valid = 1'b1; in_data = 16'h0055;
    tick();
    in_valid = 1'b0;
    total++;
    if ({wr_en, wr_addr, wr_data} !== {1'b1, AW'(0), DATA_W'(16'h0055)}) begin
      bad++; $display("FAIL ign_write got en=%b addr=%0d data=%0d want 1 0 85", wr_en, wr_addr, wr_data);
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    exp_st = {1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 3'd1};
    total++;
    if (status !== exp_st) begin bad++; $display("FAIL ign_switch got=%b want=%b", status, exp_st); end
    $display("test_ignored done");
  endtask

  task automatic test_reset_mid_bank();
    logic [5+LW:0] exp_st;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = DATA_W'(500 + i);
      tick();
    end
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    exp_st = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0};
    total++;
    if (status !== exp_st) begin bad++; $display("FAIL mid_reset_async got=%b want=%b", status, exp_st); end
    total++;
    if ({wr_addr, wr_data} !== '0) begin bad++; $display("FAIL mid_reset_wr got addr=%0d data=%0d want 0/0", wr_addr, wr_data); end
    tick(); tick();
    rst = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      in_data = DATA_W'(600 + i);
      tick();
      total++;
      if ({wr_en, wr_bank, wr_addr, wr_data} !== {1'b1, 1'b0, AW'(i), DATA_W'(600 + i)}) begin
        bad++; $display("FAIL mid_rewrite[%0d] got en=%b bank=%b addr=%0d data=%0d", i, wr_en, wr_bank, wr_addr, wr_data);
      end
    end
    in_valid = 1'b0;
    tick();
    exp_st = {1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 3'd4};
    total++;
    if (status !== exp_st) begin bad++; $display("FAIL mid_switch got=%b want=%b", status, exp_st); end
    $display("test_reset_mid_bank done");
  endtask

  // Model tracks the bank as filling / closed-waiting-for-reader / closed-and-swapping.
  task automatic test_random();
    int            m_cnt = 0, m_len = 0, m_rd_len = 0, swaps = 0;
    bit            m_closed = 0, m_swap_due = 0, m_busy = 0, m_bank = 0;
    bit            m_switch, m_wr_en, was_busy;
    logic [AW-1:0] m_wr_addr = '0;
    logic [DATA_W-1:0] m_wr_data = '0;
    logic [5+LW:0] exp_st;
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; rd_done = 1'b0;
    tick();
    rst = 1'b0;
    for (int n = 0; n < 1500; n++) begin
      in_valid = ($urandom_range(0, 99) < 70);
      in_data  = DATA_W'($urandom);
      flush    = ($urandom_range(0, 99) < 15);
      rd_done  = ($urandom_range(0, 99) < 12);
      m_switch = 0;
      m_wr_en  = 0;
      if (m_closed && m_swap_due) begin
        m_bank = !m_bank; m_rd_len = m_len; m_busy = 1; m_cnt = 0;
        m_closed = 0; m_swap_due = 0; m_switch = 1;
      end else if (m_closed) begin
        if (rd_done) begin m_busy = 0; m_swap_due = 1; end
      end else begin
        was_busy = m_busy;
        if (rd_done) m_busy = 0;
        if (in_valid) begin
          m_wr_en = 1; m_wr_addr = AW'(m_cnt); m_wr_data = in_data; m_cnt++;
        end
        if ((in_valid && m_cnt == DEPTH) || (!in_valid && flush && m_cnt > 0)) begin
          m_closed = 1; m_len = m_cnt; m_swap_due = !was_busy || rd_done;
        end
      end
      tick();
      exp_st = {!m_closed, m_wr_en, m_switch, m_bank, !m_bank, m_busy, LW'(m_rd_len)};
      total++;
      if (status !== exp_st) begin bad++; $display("FAIL rand_status[%0d] got=%b want=%b", n, status, exp_st); end
      total++;
      if ({wr_addr, wr_data} !== {m_wr_addr, m_wr_data}) begin
        bad++; $display("FAIL rand_wr[%0d] got addr=%0d data=%h want addr=%0d data=%h", n, wr_addr, wr_data, m_wr_addr, m_wr_data);
      end
      if (m_switch) begin
        swaps++;
        $display("swap %0d: wr_bank=%0d rd_len=%0d", swaps, m_bank, m_rd_len);
      end
    end
    in_valid = 1'b0; flush = 1'b0; rd_done = 1'b0;
    $display("test_random done: %0d swaps", swaps);
  endtask

  initial begin
    test_reset();
    test_fast_swap();
    test_back_pressure();
    test_flush();
    test_same_cycle_release();
    test_ignored();
    test_reset_mid_bank();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pingpang_wr_ctrl.md
# pingpang_wr_ctrl

Write-side controller placed directly upstream of the ping-pong buffer (`pingpang_top`). It accepts a valid/ready word stream, writes words sequentially into the current write bank, and issues the one-cycle `switch` pulse that swaps the banks. A swap happens only when the bank is full (or flushed) and the reader has released the other bank. While the reader still holds the other bank, the controller applies back-pressure upstream.

## Interface
- `DATA_W`, 16: word width.
- `DEPTH`, 4: words per bank, ≥2; address width `AW = $clog2(DEPTH)`; length width `LW = $clog2(DEPTH+1)`.

Ports:
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: upstream word valid.
- `in_ready` out 1: upstream may transfer; combinational, `= (state==FILL) && !rst`.
- `in_data` in DATA_W: upstream word.
- `flush` in 1: level, sampled in FILL; closes a partially filled bank.
- `wr_en` out 1: registered write strobe to the buffer.
- `wr_addr` out AW: registered write address within the bank.
- `wr_data` out DATA_W: registered write data (feeds `data_m_m2s`).
- `wr_bank` out 1: bank currently being written.
- `switch` out 1: registered one-cycle bank-swap pulse to the buffer.
- `rd_bank` out 1: bank handed to the reader, always `~wr_bank`.
- `rd_bank_valid` out 1: the reader currently owns a filled bank.
- `rd_len` out LW: number of valid words in the handed-over bank.
- `rd_done` in 1: one-cycle pulse from the consumer that releases the read bank.

## Operation
- States: FILL, SWAP, WAIT. Internal registers: `cnt` (0..DEPTH, words accepted into the current bank) and `rd_pend` (drives `rd_bank_valid`).
- **Handshake.** A transfer occurs when `in_valid && in_ready`. On a transfer, `wr_data<=in_data`, `wr_addr<=cnt`, `wr_en<=1`, and `cnt<=cnt+1`. Otherwise `wr_en<=0`; `wr_addr` and `wr_data` hold their values.
- **Close condition (FILL).** The bank closes when either:
  - a transfer brings `cnt` to DEPTH, or
  - `flush` is high with no transfer and `cnt>0`.
- **Flush edge cases.**
  - `flush` with `cnt==0` is ignored.
  - A transfer and `flush` in the same cycle: the word is accepted, and the close takes effect at the next edge only if the new `cnt` equals DEPTH. Otherwise `flush` must be held into the following cycle.
- **On close:**
  - go to SWAP if `!rd_pend || rd_done`; otherwise go to WAIT.
  - latch `len_q<=` the final `cnt`.
- **SWAP (exactly 1 cycle, `in_ready=0`).** At the exiting edge:
  - `switch<=1`, `wr_bank<=~wr_bank`;
  - `rd_len<=len_q`, `rd_pend<=1`;
  - `cnt<=0`, state FILL.
- **WAIT (`in_ready=0`).** Go to SWAP on the edge where `rd_done` is sampled high.
- **`switch` pulse.** `switch` is cleared on every edge where it is not set, so it is always a single-cycle pulse.
- **`rd_pend`.**
  - Cleared by `rd_done` in FILL or WAIT.
  - `rd_done` while `rd_pend==0`, or during SWAP, is ignored.
  - The set in SWAP takes priority.
- **`rd_len`.** Holds its value until the next swap.
- **Reset (any time, including mid-bank or in WAIT).** Aborts the operation; any partially written bank is discarded and its data lost. Post-reset values:
  - `state=FILL`, `cnt=0`, `len_q=0`;
  - `wr_en=0`, `wr_addr=0`, `wr_data=0`;
  - `wr_bank=0`, `rd_bank=1`;
  - `switch=0`, `rd_bank_valid=0`, `rd_len=0`;
  - `in_ready=0` while `rst` is high, 1 in the first cycle after release.

## Timing
- **Transfer latency.** Transfer in cycle T → `wr_en`/`wr_addr`/`wr_data` valid in T+1, with `wr_bank` unchanged in T+1.
- **Fast swap.** Last word transferred in T, swap allowed → SWAP in T+1 (last write also visible in T+1, `in_ready=0`) → `switch=1` and the new `wr_bank` in T+2, `in_ready=1` in T+2. Throughput costs 1 bubble per bank.
- **Blocked swap.** Close in T with the reader holding the other bank → WAIT from T+1. `rd_done` in cycle R → SWAP in R+1 → `switch` in R+2.
- **Accept-all-DEPTH property.** `rd_done` asserted in the same cycle as the closing transfer counts: SWAP follows directly.
- **Flush close.** `flush` sampled in cycle F → SWAP in F+1 → `switch` in F+2.
- **`rd_bank_valid`.** Rises in the same cycle as `switch`. It falls in the cycle after `rd_done` unless a swap occurs at that edge.

## Test plan
- **Reset values.** Assert `rst` mid-sim → every output at its reset value immediately (asynchronous). Release → `in_ready=1` on the next cycle.
- **Fast swap, DEPTH=4.** Stream 0,10,20,30 with `in_valid` held high, `rd_done` never asserted → `wr_addr` 0..3 on consecutive cycles, then one cycle with `in_ready=0`, then `switch=1`, `wr_bank=1`, `rd_bank=0`, `rd_len=4`, `rd_bank_valid=1`.
- **Back-pressure.** Fill a second bank of 4 words without `rd_done` → `in_ready=0` held (WAIT). Pulse `rd_done` in cycle R → `switch` at R+2, `wr_bank=0`, `in_ready=1` at R+2, with no words lost or duplicated.
- **Flush and same-cycle release.**
  - Write 2 words, then hold `flush` → `switch` with `rd_len=2`.
  - Separately, pulse `rd_done` in the same cycle as a closing transfer → no WAIT; `switch` two cycles later.
- **Ignored inputs.** `flush` with `cnt=0` → no state change. `rd_done` with `rd_bank_valid=0` → no state change.
- **Reset mid-bank.** Assert `rst` after 3 writes of a bank → `cnt=0`, `wr_bank=0`. The next 4 words are written at addresses 0..3.
